ddi_timing_ctrl: RTL and testbench
==================================

# ddi_timing_ctrl

Timing and phase controller closing the loop around the single-DDI traffic state machine. It watches the FSM's 4-bit state and measures how long the FSM has dwelt in it. It drives `timing_done`, `phase` and `sync` back into the FSM, so each light state lasts a programmed number of cycles. It also schedules normal phases against latched east/west priority demand.

## Interface
- `CNT_W`, 16: dwell counter width; all durations must be ≤ 2^CNT_W−1.
- `ALL_RED_CYCLES`, 2: ALL_RED dwell; must be ≥1.
- `GREEN_CYCLES`, 20: PHASE_1/PHASE_2 green dwell; must be ≥1.
- `YELLOW_CYCLES`, 4: dwell of every yellow state; must be ≥1.
- `PRI_GREEN_CYCLES`, 10: EASTBOUND/WESTBOUND green dwell; must be ≥1.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `state_in`  in  4  current FSM state, using the shared DDI state encoding.
- `east_req`  in  1  eastbound priority demand, level-sampled.
- `west_req`  in  1  westbound priority demand, level-sampled.
- `timing_done`  out  1  dwell-expired strobe to the FSM; combinational from registers and `state_in`.
- `phase`  out  2  registered; 00 = PHASE_1 just served, 01 = PHASE_2 just served, 10 = PRIORITY.
- `sync`  out  1  registered priority direction; 0 = east, 1 = west.
- `east_pend`, `west_pend`  out  1  registered pending-demand status.
- `bad_state`  out  1  registered, sticky illegal-state flag.

## Operation
- **Entry detect.** `state_q` registers `state_in`. A cycle is an *entry cycle* when `state_in != state_q`.
- **Dwell counter.** `elapsed` loads 1 at the edge ending an entry cycle. Otherwise it increments, saturating at all-ones. Effective count is `eff = entry ? 0 : elapsed`.
- **timing_done.** High when `eff == DUR(state_in) − 1` for a timed state. DUR by state:
  - ALL_RED → `ALL_RED_CYCLES`
  - PHASE_x_GREEN → `GREEN_CYCLES`
  - any YELLOW → `YELLOW_CYCLES`
  - EAST/WESTBOUND_GREEN → `PRI_GREEN_CYCLES`
- **Untimed states.** MAINTENANCE and codes 1010–1111 hold `timing_done` at 0. An illegal code sets `bad_state`, which clears only on reset.
- **Demand latch.** `east_req` sets `east_pend`; it clears in the entry cycle of EASTBOUND_GREEN. If set and clear coincide, clear wins. West is symmetric.
- **Phase decision.** Taken at the edge where a YELLOW state has `timing_done` = 1, so the value is stable for all of the following ALL_RED.
  - Exiting a normal yellow with any demand pending: `phase` = 10. `sync` goes to the pending side; if both are pending, it goes opposite to `last_pri`. `last_normal` records PHASE_1 or PHASE_2 to match the yellow exited.
  - Exiting a normal yellow with no demand: `phase` = PHASE_1 (from PHASE_1_YELLOW) or PHASE_2 (from PHASE_2_YELLOW).
  - Exiting a priority yellow: `phase` = `last_normal`, so priority never runs back-to-back. `last_pri` is updated to the side just served.
- **Maintenance.** Counter and phase logic are frozen. Pending bits still latch. On exit to ALL_RED, `phase` is forced to 01 in that entry cycle, and ALL_RED is timed fresh.

## Timing
- **Reset values.** `state_q` = ALL_RED, `elapsed` = 0, `phase` = 01, `sync` = 0, `last_pri` = west, `last_normal` = 01; `east_pend`, `west_pend` and `bad_state` = 0.
- **Reset with `state_in` = ALL_RED.** `timing_done` = 0 while in reset, because it is gated by `rst_n`.
- **Dwell.** A state entered at edge E0 is left by the FSM at edge E0 + DUR: exactly DUR cycles, with one `timing_done` cycle per visit.
- **Demand latency.** Demand sampled in cycle n is visible on `*_pend` in cycle n+1. It affects only the next yellow exit.
- **Reset mid-operation.** Asynchronous. All registers return to reset values immediately; pending demand is lost.
- **Saturated counter.** `timing_done` does not re-fire once the counter has saturated.

## Structure
- Shared package `ddi_defs` holds the state codes ALL_RED…MAINTENANCE, the phase codes, and EAST_PRIORITY/WEST_PRIORITY. The state-machine block already imports these same constants.
- Sub-module `ddi_dwell_counter` contains `state_q`, the entry detect and the saturating `elapsed` counter, and outputs `entry` and `eff`.
- The top level contains the DUR decode, `timing_done`, the demand latches and the phase scheduler.

## Test plan
All scenarios use default parameters, and the bench closes the loop with the DDI state machine.
- **Reset release:** release reset with FSM in ALL_RED → `timing_done` high in cycle 1 only, `phase` = 01, FSM enters PHASE_1_GREEN at edge 2.
- **Green dwell:** PHASE_1_GREEN lasts exactly 20 cycles, `timing_done` high only in cycle 19; PHASE_1_YELLOW then lasts exactly 4 cycles.
- **Single priority request:** one-cycle `east_req` pulse during PHASE_1_GREEN → at the yellow exit `phase` = 10 and `sync` = 0. `east_pend` drops in the EASTBOUND_GREEN entry cycle. That green lasts 10 cycles. After EASTBOUND_YELLOW, `phase` = 00 and the FSM enters PHASE_2_GREEN.
- **Simultaneous requests:** `east_req` and `west_req` together → east served first. A normal phase follows, then west with `sync` = 1.
- **Maintenance:** 50 cycles in MAINTENANCE → `timing_done` stays 0 throughout. On return to ALL_RED, `phase` = 01 and exactly 2 ALL_RED cycles follow.
- **Illegal state and mid-green reset:** force `state_in` = 1100 → `bad_state` = 1 and sticky, `timing_done` = 0. Assert `rst_n` mid-green → all outputs take reset values in the same cycle.

Source files
------------

// File: rtl/ddi_defs_pkg.sv
// Shared DDI constants: FSM state codes, phase codes and priority directions.
// The state-machine block imports this same package.
package ddi_defs;

  localparam logic [3:0] ALL_RED          = 4'd0;
  localparam logic [3:0] PHASE_1_GREEN    = 4'd1;
  localparam logic [3:0] PHASE_1_YELLOW   = 4'd2;
  localparam logic [3:0] PHASE_2_GREEN    = 4'd3;
  localparam logic [3:0] PHASE_2_YELLOW   = 4'd4;
  localparam logic [3:0] EASTBOUND_GREEN  = 4'd5;
  localparam logic [3:0] EASTBOUND_YELLOW = 4'd6;
  localparam logic [3:0] WESTBOUND_GREEN  = 4'd7;
  localparam logic [3:0] WESTBOUND_YELLOW = 4'd8;
  localparam logic [3:0] MAINTENANCE      = 4'd9;

  typedef enum logic [1:0] {
    PHASE_1   = 2'b00,
    PHASE_2   = 2'b01,
    PHASE_PRI = 2'b10
  } phase_e;

  localparam logic EAST_PRIORITY = 1'b0;
  localparam logic WEST_PRIORITY = 1'b1;

  // Codes above MAINTENANCE are not part of the shared encoding.
  function automatic logic is_illegal(input logic [3:0] code);
    return (code > MAINTENANCE);
  endfunction

endpackage

// File: rtl/ddi_dwell_counter.sv
// Tracks the previous FSM state and counts how long the current state has
// been held; eff reads 0 in the cycle a new state is first seen.
module ddi_dwell_counter
  import ddi_defs::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       state_in,
  input  logic             freeze,
  output logic [3:0]       state_q,
  output logic             entry,
  output logic [CNT_W-1:0] eff
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] elapsed;

  assign entry = (state_in != state_q);
  assign eff   = entry ? {CNT_W{1'b0}} : elapsed;

  // State history and saturating dwell count; frozen while in maintenance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALL_RED;
      elapsed <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_in;
      if (entry) begin
        elapsed <= CNT_ONE;
      end else if (freeze || (elapsed == CNT_MAX)) begin
        elapsed <= elapsed;
      end else begin
        elapsed <= elapsed + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/ddi_timing_ctrl.sv
// Dwell timing and phase scheduling for the single-DDI traffic FSM: expires
// each light state, latches priority demand and picks the next phase.
module ddi_timing_ctrl
  import ddi_defs::*;
#(
  parameter int CNT_W            = 16,
  parameter int ALL_RED_CYCLES   = 2,
  parameter int GREEN_CYCLES     = 20,
  parameter int YELLOW_CYCLES    = 4,
  parameter int PRI_GREEN_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state_in,
  input  logic       east_req,
  input  logic       west_req,
  output logic       timing_done,
  output logic [1:0] phase,
  output logic       sync,
  output logic       east_pend,
  output logic       west_pend,
  output logic       bad_state
);

  localparam logic [CNT_W-1:0] LIM_ALL_RED = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_GREEN   = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_YELLOW  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_PRI     = CNT_W'(PRI_GREEN_CYCLES - 1);

  logic [3:0]       state_q;
  logic             entry;
  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] lim;
  logic             timed;
  logic             maint_exit;
  phase_e           phase_q;
  phase_e           last_normal;
  logic             last_pri;

  ddi_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .state_in (state_in),
    .freeze   (state_in == MAINTENANCE),
    .state_q  (state_q),
    .entry    (entry),
    .eff      (eff)
  );

  // Last count value of each timed state; untimed states never expire.
  always_comb begin
    lim   = {CNT_W{1'b0}};
    timed = 1'b1;
    case (state_in)
      ALL_RED:                            lim = LIM_ALL_RED;
      PHASE_1_GREEN, PHASE_2_GREEN:       lim = LIM_GREEN;
      PHASE_1_YELLOW, PHASE_2_YELLOW,
      EASTBOUND_YELLOW, WESTBOUND_YELLOW: lim = LIM_YELLOW;
      EASTBOUND_GREEN, WESTBOUND_GREEN:   lim = LIM_PRI;
      default:                            timed = 1'b0;
    endcase
  end

  assign timing_done = rst_n & timed & (eff == lim);
  assign maint_exit  = entry && (state_q == MAINTENANCE) && (state_in == ALL_RED);
  assign phase       = phase_q;

  // Demand latches, sticky illegal-state flag and phase decisions at yellow exits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      east_pend   <= 1'b0;
      west_pend   <= 1'b0;
      bad_state   <= 1'b0;
      phase_q     <= PHASE_2;
      sync        <= EAST_PRIORITY;
      last_pri    <= WEST_PRIORITY;
      last_normal <= PHASE_2;
    end else begin
      east_pend <= (east_pend | east_req) & ~(entry && (state_in == EASTBOUND_GREEN));
      west_pend <= (west_pend | west_req) & ~(entry && (state_in == WESTBOUND_GREEN));
      bad_state <= bad_state | is_illegal(state_in);
      if (maint_exit) begin
        phase_q <= PHASE_2;
      end else if (timing_done) begin
        case (state_in)
          PHASE_1_YELLOW, PHASE_2_YELLOW: begin
            last_normal <= (state_in == PHASE_1_YELLOW) ? PHASE_1 : PHASE_2;
            if (east_pend || west_pend) begin
              phase_q <= PHASE_PRI;
              // Tie goes to whichever side was not served most recently.
              sync    <= (east_pend && west_pend) ? ~last_pri : west_pend;
            end else begin
              phase_q <= (state_in == PHASE_1_YELLOW) ? PHASE_1 : PHASE_2;
            end
          end
          EASTBOUND_YELLOW: begin
            phase_q  <= last_normal;
            last_pri <= EAST_PRIORITY;
          end
          WESTBOUND_YELLOW: begin
            phase_q  <= last_normal;
            last_pri <= WEST_PRIORITY;
          end
          default: phase_q <= phase_q;
        endcase
      end else begin
        phase_q <= phase_q;
      end
    end
  end

endmodule

// File: tb/tb_ddi_timing_ctrl.sv
// Closed-loop bench: a small DDI FSM model reacts to timing_done/phase/sync,
// and directed steps check dwell lengths, demand handling and reset behaviour.
module tb_ddi_timing_ctrl;
  import ddi_defs::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state_in;
  logic       east_req, west_req;
  logic       timing_done;
  logic [1:0] phase;
  logic       sync, east_pend, west_pend, bad_state;

  logic [3:0] fsm_state;
  logic [3:0] force_val;
  logic       force_en;
  logic       maint_cmd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign state_in = force_en ? force_val : fsm_state;

  ddi_timing_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_in    (state_in),
    .east_req    (east_req),
    .west_req    (west_req),
    .timing_done (timing_done),
    .phase       (phase),
    .sync        (sync),
    .east_pend   (east_pend),
    .west_pend   (west_pend),
    .bad_state   (bad_state)
  );

  // DDI state machine model driven by the controller outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_state <= ALL_RED;
    else if (maint_cmd && fsm_state != MAINTENANCE) fsm_state <= MAINTENANCE;
    else if (!maint_cmd && fsm_state == MAINTENANCE) fsm_state <= ALL_RED;
    else if (timing_done && !force_en) begin
      case (fsm_state)
        ALL_RED: begin
          if (phase == 2'b10) fsm_state <= sync ? WESTBOUND_GREEN : EASTBOUND_GREEN;
          else if (phase == 2'b00) fsm_state <= PHASE_2_GREEN;
          else fsm_state <= PHASE_1_GREEN;
        end
        PHASE_1_GREEN:    fsm_state <= PHASE_1_YELLOW;
        PHASE_2_GREEN:    fsm_state <= PHASE_2_YELLOW;
        EASTBOUND_GREEN:  fsm_state <= EASTBOUND_YELLOW;
        WESTBOUND_GREEN:  fsm_state <= WESTBOUND_YELLOW;
        default:          fsm_state <= ALL_RED;
      endcase
    end
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
    int k = 0;
    while (state_in !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, state_in, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},  4'(timing_done), 4'd0);
    check({tag, "_phase"}, 4'(phase),       4'd1);
    check({tag, "_sync"},  4'(sync),        4'd0);
    check({tag, "_epend"}, 4'(east_pend),   4'd0);
    check({tag, "_wpend"}, 4'(west_pend),   4'd0);
    check({tag, "_bad"},   4'(bad_state),   4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; east_req = 1'b0; west_req = 1'b0;
    force_en = 1'b0; force_val = 4'd0; maint_cmd = 1'b0;
    @(negedge clk); @(negedge clk);
    check_reset_outputs("in_reset");

    // Reset release: ALL_RED expires in cycle 1, PHASE_1_GREEN at edge 2.
    rst_n = 1'b1;
    check("rel_c0_done", 4'(timing_done), 4'd0);
    @(negedge clk);
    check("rel_c1_done", 4'(timing_done), 4'd1);
    check("rel_c1_phase", 4'(phase), 4'd1);
    @(negedge clk);
    check("rel_p1g", state_in, PHASE_1_GREEN);

    // Green dwell with a one-cycle east request in cycle 5.
    for (int k = 0; k < 20; k++) begin
      check("p1g_state", state_in, PHASE_1_GREEN);
      check("p1g_done", 4'(timing_done), 4'(k == 19));
      if (k == 6) check("p1g_epend", 4'(east_pend), 4'd1);
      if (k == 5) east_req = 1'b1;
      if (k == 6) east_req = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      check("p1y_state", state_in, PHASE_1_YELLOW);
      check("p1y_done", 4'(timing_done), 4'(k == 3));
      @(negedge clk);
    end
    check("ar1_state", state_in, ALL_RED);
    check("ar1_phase", 4'(phase), 4'd2);
    check("ar1_sync", 4'(sync), 4'd0);
    @(negedge clk);
    check("ar1_done", 4'(timing_done), 4'd1);
    @(negedge clk);
    check("ebg_entry_epend", 4'(east_pend), 4'd1);
    for (int k = 0; k < 10; k++) begin
      check("ebg_state", state_in, EASTBOUND_GREEN);
      check("ebg_done", 4'(timing_done), 4'(k == 9));
      if (k == 1) check("ebg_epend_clr", 4'(east_pend), 4'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      check("eby_state", state_in, EASTBOUND_YELLOW);
      @(negedge clk);
    end
    check("ar2_phase", 4'(phase), 4'd0);
    @(negedge clk); @(negedge clk);
    check("ar2_p2g", state_in, PHASE_2_GREEN);

    // Asynchronous reset mid-green.
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests: east first, normal phase, then west.
    wait_state("sim_p1g", PHASE_1_GREEN, 10);
    east_req = 1'b1; west_req = 1'b1;
    @(negedge clk);
    east_req = 1'b0; west_req = 1'b0;
    check("sim_epend", 4'(east_pend), 4'd1);
    check("sim_wpend", 4'(west_pend), 4'd1);
    wait_state("sim_ar1", ALL_RED, 40);
    check("sim_ar1_phase", 4'(phase), 4'd2);
    check("sim_ar1_sync", 4'(sync), 4'd0);
    wait_state("sim_ebg", EASTBOUND_GREEN, 10);
    check("sim_ebg_wpend", 4'(west_pend), 4'd1);
    wait_state("sim_ar2", ALL_RED, 30);
    check("sim_ar2_phase", 4'(phase), 4'd0);
    wait_state("sim_p2g", PHASE_2_GREEN, 10);
    wait_state("sim_ar3", ALL_RED, 40);
    check("sim_ar3_phase", 4'(phase), 4'd2);
    check("sim_ar3_sync", 4'(sync), 4'd1);
    wait_state("sim_wbg", WESTBOUND_GREEN, 10);
    @(negedge clk);
    check("sim_wpend_clr", 4'(west_pend), 4'd0);

    // Maintenance: no expiry, demand still latches, fresh ALL_RED on exit.
    maint_cmd = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      check("mnt_state", state_in, MAINTENANCE);
      check("mnt_done", 4'(timing_done), 4'd0);
      if (k == 10) east_req = 1'b1;
      if (k == 11) east_req = 1'b0;
      @(negedge clk);
    end
    check("mnt_epend", 4'(east_pend), 4'd1);
    maint_cmd = 1'b0;
    @(negedge clk);
    check("mnt_ar_state", state_in, ALL_RED);
    check("mnt_ar_c0_done", 4'(timing_done), 4'd0);
    @(negedge clk);
    check("mnt_ar_c1_state", state_in, ALL_RED);
    check("mnt_ar_c1_done", 4'(timing_done), 4'd1);
    check("mnt_ar_phase", 4'(phase), 4'd1);
    @(negedge clk);
    check("mnt_p1g", state_in, PHASE_1_GREEN);

    // Illegal state code: sticky flag, no expiry, cleared only by reset.
    force_val = 4'b1100;
    force_en  = 1'b1;
    #1 check("ill_done", 4'(timing_done), 4'd0);
    @(negedge clk);
    check("ill_bad", 4'(bad_state), 4'd1);
    check("ill_done2", 4'(timing_done), 4'd0);
    force_en = 1'b0;
    @(negedge clk); @(negedge clk);
    check("ill_sticky", 4'(bad_state), 4'd1);
    rst_n = 1'b0;
    #1 check("ill_reset_bad", 4'(bad_state), 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
